booth_mult_seq: RTL and testbench
=================================

BOOTH_MULT_SEQ -- requirements
Module: booth_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand width in bits (even, >= 4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply, sampled on the clk rising edge.
REQ-005 SHALL have port multiplicand, input, WIDTH bits: signed two's-complement operand M.
REQ-006 SHALL have port multiplier, input, WIDTH bits: signed two's-complement operand Q.
REQ-007 SHALL have port busy, output, 1 bit: high while iterating.
REQ-008 SHALL have port done, output, 1 bit: single-cycle pulse marking product valid.
REQ-009 SHALL have port product, output, 2*WIDTH bits: signed result M*Q.

Function
REQ-010 SHALL implement an internal FSM with states IDLE, RUN and DONE.
REQ-011 SHALL, in IDLE or DONE with start=1 at an edge, load M, Q, A=0, Q-1=0 and count=ITER, then enter RUN.
REQ-012 SHALL use ITER=WIDTH in radix-2 mode.
REQ-013 SHALL hold the internal accumulator A at WIDTH+1 bits (radix-2) so that M=-2^(WIDTH-1) cannot overflow.
REQ-014 SHALL, per RUN cycle in radix-2 mode, apply {Q[0],Q-1}: 01 -> A+=M, 10 -> A-=M, 00/11 -> no change.
REQ-015 SHALL then arithmetic-shift {A,Q,Q-1} right by one bit and decrement count, in the same cycle.
REQ-016 SHALL move RUN->DONE on the edge that completes the iteration with count==1.
REQ-017 SHALL give a latency such that start is sampled at edge k and done=1 holds for exactly the cycle after edge k+ITER.
REQ-018 SHALL drive product from {A[WIDTH-1:0],Q}: exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1).
REQ-019 SHALL hold product stable from DONE until the next accepted start; it SHALL NOT change while in RUN before completion.
REQ-020 SHALL hold busy=1 exactly while in RUN.
REQ-021 SHALL ignore start while in RUN; operands and progress are unaffected.
REQ-022 SHALL treat start=1 in DONE as an accepted back-to-back start: done still pulses that cycle and the next operation begins.
REQ-023 SHALL move DONE->IDLE after one cycle when start=0.
REQ-024 SHALL sample operands only on the accepting edge; later operand changes have no effect.

Reset
REQ-025 SHALL, on rst_n=0, asynchronously force state=IDLE, busy=0, done=0, product=0, A=0, Q=0, Q-1=0 and count=0.
REQ-026 SHALL, on reset during RUN, abort the operation with no done pulse.
REQ-027 SHALL accept the first start on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL, when macro BOOTH_RADIX4_EN is defined, use radix-4 modified Booth with ITER=WIDTH/2.
REQ-029 SHALL, in radix-4 mode, recode {Q[1],Q[0],Q-1} into a digit in {0,+M,+2M,-M,-2M}.
REQ-030 SHALL, in radix-4 mode, widen A to WIDTH+2 bits and shift {A,Q,Q-1} arithmetically right by two bits per cycle.
REQ-031 SHALL, without the BOOTH_RADIX4_EN macro, use radix-2 as in REQ-014; product values are identical in both modes, only latency differs.

Verification (WIDTH=16)
REQ-032 SHALL cover: M=3, Q=-5, start at edge k -> done at cycle k+16 (k+8 radix-4), product=0xFFFFFFF1, busy high 16 (8) cycles.
REQ-033 SHALL cover: M=-32768, Q=-32768 -> product=0x40000000; M=32767, Q=-32768 -> product=0xC0008000.
REQ-034 SHALL cover: start pulsed again at RUN cycle 5 with new operands -> ignored, original result 0xFFFFFFF1 delivered on schedule.
REQ-035 SHALL cover: rst_n low at RUN cycle 7 -> busy=0, product=0 immediately, no done; a new start after release gives a correct result.
REQ-036 SHALL cover: start held high through DONE with M=0, Q=1234 -> done pulses, second op yields product=0 after a further 16 (8) cycles.
REQ-037 SHALL cover: 1000 random signed pairs -> product equals the reference signed 32-bit multiply in both radix modes.

Source files
------------

// File: rtl/booth_mult_seq.sv
// Sequential signed Booth multiplier: radix-2 by default, radix-4 modified Booth
// when BOOTH_RADIX4_EN is defined.
module booth_mult_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_RADIX4_EN
   localparam int unsigned ITER = WIDTH / 2;
   localparam int unsigned AW   = WIDTH + 2;
`else
   localparam int unsigned ITER = WIDTH;
   localparam int unsigned AW   = WIDTH + 1;
`endif
   localparam int unsigned CW = $clog2(ITER + 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q;
   logic [AW-1:0]    a_q, a_sum, a_nxt, m_ext, addend;
   logic [WIDTH-1:0] m_q, q_q, q_nxt;
   logic             qm1_q, qm1_nxt;
   logic [CW-1:0]    count_q;

   // A is wider than M so that -2^(WIDTH-1) (and 2M in radix-4) never overflows
   assign m_ext = {{(AW - WIDTH){m_q[WIDTH-1]}}, m_q};

   always_comb begin
      addend = '0;
`ifdef BOOTH_RADIX4_EN
      unique case ({q_q[1:0], qm1_q})
         3'b001, 3'b010: addend = m_ext;
         3'b011:         addend = {m_ext[AW-2:0], 1'b0};
         3'b100:         addend = '0 - {m_ext[AW-2:0], 1'b0};
         3'b101, 3'b110: addend = '0 - m_ext;
         default:        addend = '0;
      endcase
      a_sum   = a_q + addend;
      a_nxt   = {{2{a_sum[AW-1]}}, a_sum[AW-1:2]};
      q_nxt   = {a_sum[1:0], q_q[WIDTH-1:2]};
      qm1_nxt = q_q[1];
`else
      case ({q_q[0], qm1_q})
         2'b01:   addend = m_ext;
         2'b10:   addend = '0 - m_ext;
         default: addend = '0;
      endcase
      a_sum   = a_q + addend;
      a_nxt   = {a_sum[AW-1], a_sum[AW-1:1]};
      q_nxt   = {a_sum[0], q_q[WIDTH-1:1]};
      qm1_nxt = q_q[0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         count_q <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  m_q     <= multiplicand;
                  q_q     <= multiplier;
                  a_q     <= '0;
                  qm1_q   <= 1'b0;
                  count_q <= CW'(ITER);
                  busy    <= 1'b1;
                  state_q <= StRun;
               end else begin
                  state_q <= StIdle;
               end
            end
            StRun: begin
               a_q     <= a_nxt;
               q_q     <= q_nxt;
               qm1_q   <= qm1_nxt;
               count_q <= count_q - CW'(1);
               if (count_q == CW'(1)) begin
                  product <= {a_nxt[WIDTH-1:0], q_nxt};
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_q <= StDone;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq (WIDTH=16); honours BOOTH_RADIX4_EN for latency.
module tb_booth_mult_seq;

   localparam int unsigned W = 16;
`ifdef BOOTH_RADIX4_EN
   localparam int unsigned ITER = W / 2;
`else
   localparam int unsigned ITER = W;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            start;
   logic [W-1:0]    multiplicand;
   logic [W-1:0]    multiplier;
   logic            busy;
   logic            done;
   logic [2*W-1:0]  product;

   typedef struct {
      logic [31:0] prod;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   booth_mult_seq #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever done is presented.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1, expected no done (cycle %0d)", cyc);
            end else begin
               check("product", 64'(product), 64'(sb[0].prod));
               check("done_cycle", 64'(cyc), 64'(sb[0].due));
               void'(sb.pop_front());
            end
         end else if (sb.size() != 0 && cyc > sb[0].due) begin
            n_cmp++;
            n_bad++;
            $display("FAIL late_done: got no done, expected done at cycle %0d (now %0d)",
                     sb[0].due, cyc);
            void'(sb.pop_front());
         end
      end
   end

   task automatic sync();
      @(negedge clk);
      #2;
   endtask

   // Call at negedge+2: the next rising edge accepts the operands.
   task automatic start_op(input logic [15:0] m, input logic [15:0] q, input logic [31:0] exp);
      exp_t e;
      multiplicand = m;
      multiplier   = q;
      start        = 1'b1;
      e.prod = exp;
      e.due  = cyc + 1 + ITER;
      sb.push_back(e);
      @(posedge clk);
      #1;
      start        = 1'b0;
      multiplicand = 16'($urandom);
      multiplier   = 16'($urandom);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < int'(ITER) + 6; i++) begin
         sync();
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   logic [15:0] vm[10] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'h8000,
                           16'h0064, 16'hFFF9, 16'h04D2, 16'h8000, 16'h0000};
   logic [15:0] vq[10] = '{16'h8000, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0001,
                           16'h00C8, 16'h0009, 16'hFFFF, 16'h7FFF, 16'h04D2};
   logic [31:0] vp[10] = '{32'h40000000, 32'hC0008000, 32'h00000001, 32'h3FFF0001,
                           32'hFFFF8000, 32'h00004E20, 32'hFFFFFFC1, 32'hFFFFFB2E,
                           32'hC0008000, 32'h00000000};

   initial begin
      int          busy_cnt;
      logic        changed;
      int unsigned k;
      exp_t        e;
      logic signed [15:0] rm, rq;
      logic signed [31:0] rp;

      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", 64'(product), 64'd0);

      // First start on the very first edge after reset release; count busy cycles.
      #2;
      rst_n = 1'b1;
      start_op(16'd3, 16'hFFFB, 32'hFFFFFFF1);
      busy_cnt = 0;
      changed  = 1'b0;
      for (int i = 0; i < int'(ITER) + 3; i++) begin
         @(negedge clk);
         if (busy === 1'b1) begin
            busy_cnt++;
            if (product !== 32'h0) changed = 1'b1;
         end
      end
      check("busy_cycles", 64'(busy_cnt), 64'(ITER));
      check("product_stable_in_run", 64'(changed), 64'd0);
      wait_drain();

      // Start pulsed mid-run with other operands must be ignored.
      sync();
      start_op(16'd3, 16'hFFFB, 32'hFFFFFFF1);
      repeat (4) @(posedge clk);
      #1;
      multiplicand = 16'd7;
      multiplier   = 16'd7;
      start        = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_drain();

      // Reset in the middle of a run aborts it.
      sync();
      start_op(16'hFFF9, 16'd9, 32'hFFFFFFC1);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_product", 64'(product), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      start_op(16'd100, 16'd200, 32'h00004E20);
      wait_drain();

      // Product holds in idle after completion.
      repeat (3) @(negedge clk);
      #1;
      check("idle_hold_product", 64'(product), 64'h4E20);
      check("idle_busy", 64'(busy), 64'd0);

      // Back-to-back: start held high through DONE.
      sync();
      k            = cyc + 1;
      multiplicand = 16'd3;
      multiplier   = 16'hFFFB;
      start        = 1'b1;
      e.prod = 32'hFFFFFFF1;
      e.due  = k + ITER;
      sb.push_back(e);
      e.prod = 32'h0;
      e.due  = k + ITER + 1 + ITER;
      sb.push_back(e);
      @(posedge clk);
      #1;
      multiplicand = 16'd0;
      multiplier   = 16'd1234;
      do begin
         @(posedge clk);
         #1;
      end while (cyc < k + ITER + 1);
      start = 1'b0;
      check("b2b_busy", 64'(busy), 64'd1);
      wait_drain();

      foreach (vm[i]) begin
         sync();
         start_op(vm[i], vq[i], vp[i]);
         wait_drain();
      end

      for (int i = 0; i < 1000; i++) begin
         rm = 16'($urandom);
         rq = 16'($urandom);
         rp = rm * rq;
         sync();
         start_op(rm, rq, rp);
         wait_drain();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 5 ms");
      $fatal(1, "watchdog expired");
   end

endmodule
